// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: load alignment/extension, register-file write, commit/trap report.
// Optional misaligned-access traps enabled by YSYX_25020037_MISALIGN_CHECK_EN.
module ysyx_25020037_wbu (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        wbu_ready,
    input  logic [63:0] lu_to_wu_bus,
    input  logic [43:0] du_to_wu_bus,
    input  logic        access_fault,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wbu_valid,
    input  logic        ifu_ready,
    output logic [31:0] commit_pc,
    output logic        trap_valid,
    output logic [3:0]  trap_cause,
    output logic [31:0] trap_tval,
    output logic [63:0] instret
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;

    logic        hs, done;
    logic [31:0] addr, data, pc, shifted, ld_data, wdata;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [2:0]  size;
    logic        rd_we, is_load, is_uns, is_store, mem_op;
    logic        misalign, fault, trap, we;
    logic [3:0]  cause;

    assign addr     = lu_to_wu_bus[63:32];
    assign data     = lu_to_wu_bus[31:0];
    assign pc       = du_to_wu_bus[31:0];
    assign rd       = du_to_wu_bus[36:32];
    assign rd_we    = du_to_wu_bus[37];
    assign is_load  = du_to_wu_bus[38];
    assign size     = du_to_wu_bus[41:39];
    assign is_uns   = du_to_wu_bus[42];
    assign is_store = du_to_wu_bus[43];

    assign off     = addr[1:0];
    assign shifted = data >> {off, 3'b000};
    assign mem_op  = is_load | is_store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wbu_ready = 1'b0;
        wbu_valid = 1'b0;
        unique case (state)
            IDLE: begin
                wbu_ready = 1'b1;
                if (lsu_valid) state_nxt = BUSY;
            end
            BUSY: begin
                wbu_valid = 1'b1;
                if (ifu_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hs   = lsu_valid & wbu_ready;
    assign done = wbu_valid & ifu_ready;

    always_comb begin
        ld_data = shifted;
        unique case (1'b1)
            size[0]: ld_data = {{24{~is_uns & shifted[7]}}, shifted[7:0]};
            size[1]: ld_data = {{16{~is_uns & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

`ifdef YSYX_25020037_MISALIGN_CHECK_EN
    assign misalign = mem_op &
                      ((size[1] & (off == 2'd3)) |
                       (size[2] & (off != 2'd0)));
`else
    assign misalign = 1'b0;
`endif

    assign fault = access_fault & mem_op;
    assign trap  = misalign | fault;
    assign we    = rd_we & (rd != 5'd0) & ~trap;
    assign wdata = is_load ? ld_data : addr;

    // Misalignment takes priority over a bus fault
    always_comb begin
        cause = 4'd0;
        if (misalign)   cause = is_load ? 4'd4 : 4'd6;
        else if (fault) cause = is_load ? 4'd5 : 4'd7;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'd0;
            commit_pc  <= 32'd0;
            trap_valid <= 1'b0;
            trap_cause <= 4'd0;
            trap_tval  <= 32'd0;
            instret    <= 64'd0;
        end else begin
            rf_we <= hs & we;
            if (hs) begin
                rf_waddr   <= rd;
                rf_wdata   <= wdata;
                commit_pc  <= pc;
                trap_valid <= trap;
                trap_cause <= cause;
                trap_tval  <= trap ? addr : 32'd0;
            end
            if (done && !trap_valid) instret <= instret + 64'd1;
        end
    end

endmodule
